// File: rtl/seg7_scan_ctrl.sv
// Multiplexed common-anode 7-segment scan controller: double-buffered digits, per-digit
// decimal points, leading-zero blanking, PWM brightness and an anti-ghosting blank interval.
module seg7_scan_ctrl #(
  parameter int N_DIG     = 4,
  parameter int FCLK_KHZ  = 50000,
  parameter int FSCAN_KHZ = 1,
  parameter int BLANK_CYC = 16,
  parameter int BRIGHT_W  = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*N_DIG-1:0]    dat,
  input  logic [N_DIG-1:0]      dp,
  input  logic                  dat_stb,
  input  logic                  blank_lz,
  input  logic [BRIGHT_W-1:0]   bright,
  output logic [N_DIG-1:0]      AN,
  output logic [6:0]            seg,
  output logic                  seg_P,
  output logic                  frame_sync
);

  localparam int P     = FCLK_KHZ / FSCAN_KHZ;
  localparam int CNT_W = (P > 1) ? $clog2(P) : 1;
  localparam int IDX_W = (N_DIG > 1) ? $clog2(N_DIG) : 1;
  localparam int OW    = CNT_W + 1;
  localparam int U     = (P - BLANK_CYC) >> BRIGHT_W;

  if (P <= BLANK_CYC + 2**BRIGHT_W) begin : g_bad_params
    $error("seg7_scan_ctrl: slot length too short for blank interval plus brightness steps");
  end

  logic [CNT_W-1:0]   r_cnt;
  logic [IDX_W-1:0]   r_idx;
  logic [4*N_DIG-1:0] r_act_dat, r_pend_dat;
  logic [N_DIG-1:0]   r_act_dp, r_pend_dp;
  logic               r_pend_vld;
  logic [OW-1:0]      r_on_len;
  logic               r_lz;
  logic [N_DIG-1:0]   r_an;
  logic [6:0]         r_seg;
  logic               r_seg_p;
  logic               r_fsync;

  logic               w_wrap, w_frame_start, w_xfer;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [IDX_W-1:0]   w_idx_nxt;
  logic [4*N_DIG-1:0] w_act_dat_nxt;
  logic [N_DIG-1:0]   w_act_dp_nxt;
  logic [OW-1:0]      w_on_len_nxt;
  logic               w_lz_nxt;
  logic [N_DIG-1:0]   w_lz_mask;
  logic               w_run;
  logic [3:0]         w_nib;
  logic               w_dp_sel;
  logic               w_blank;
  logic [OW-1:0]      w_cnt_ext;
  logic               w_an_on;
  logic [N_DIG-1:0]   w_an_nxt;

  function automatic logic [6:0] hex2seg(input logic [3:0] h);
    case (h)
      4'h0: hex2seg = 7'h40;
      4'h1: hex2seg = 7'h79;
      4'h2: hex2seg = 7'h24;
      4'h3: hex2seg = 7'h30;
      4'h4: hex2seg = 7'h19;
      4'h5: hex2seg = 7'h12;
      4'h6: hex2seg = 7'h02;
      4'h7: hex2seg = 7'h78;
      4'h8: hex2seg = 7'h00;
      4'h9: hex2seg = 7'h10;
      4'hA: hex2seg = 7'h08;
      4'hB: hex2seg = 7'h03;
      4'hC: hex2seg = 7'h46;
      4'hD: hex2seg = 7'h21;
      4'hE: hex2seg = 7'h06;
      default: hex2seg = 7'h0E;
    endcase
  endfunction

  // Outputs are decoded from next-state values so the pins show slot cycle s == r_cnt.
  // NOTE: every variable gets a default at the top of always_comb; a path that leaves one unassigned infers a latch.
  always_comb begin
    w_wrap    = (r_cnt == CNT_W'(P - 1));
    w_cnt_nxt = w_wrap ? '0 : r_cnt + 1'b1;
    w_idx_nxt = r_idx;
    if (w_wrap) begin
      w_idx_nxt = (r_idx == IDX_W'(N_DIG - 1)) ? '0 : r_idx + 1'b1;
    end
    w_frame_start = w_wrap && (w_idx_nxt == '0);
    w_xfer        = w_frame_start && r_pend_vld;
    w_act_dat_nxt = w_xfer ? r_pend_dat : r_act_dat;
    w_act_dp_nxt  = w_xfer ? r_pend_dp  : r_act_dp;
    w_on_len_nxt  = w_wrap ? OW'(U) * (OW'(bright) + OW'(1)) : r_on_len;
    w_lz_nxt      = w_wrap ? blank_lz : r_lz;

    // Leading-zero run from the top digit; digit 0 is never part of it.
    w_lz_mask = '0;
    w_run     = 1'b1;
    for (int k = N_DIG - 1; k >= 1; k--) begin
      w_run        = w_run && (w_act_dat_nxt[4*k +: 4] == 4'h0) && !w_act_dp_nxt[k];
      w_lz_mask[k] = w_run;
    end

    w_nib    = '0;
    w_dp_sel = 1'b0;
    w_blank  = 1'b0;
    for (int k = 0; k < N_DIG; k++) begin
      if (w_idx_nxt == IDX_W'(k)) begin
        w_nib    = w_act_dat_nxt[4*k +: 4];
        w_dp_sel = w_act_dp_nxt[k];
        w_blank  = w_lz_nxt && w_lz_mask[k];
      end
    end

    w_cnt_ext = {1'b0, w_cnt_nxt};
    w_an_on   = !w_blank && (w_cnt_ext >= OW'(BLANK_CYC)) &&
                (w_cnt_ext < OW'(BLANK_CYC) + w_on_len_nxt);
    w_an_nxt  = '1;
    for (int k = 0; k < N_DIG; k++) begin
      if (w_idx_nxt == IDX_W'(k)) w_an_nxt[k] = !w_an_on;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt      <= '0;
      r_idx      <= '0;
      r_act_dat  <= '0;
      r_act_dp   <= '0;
      r_pend_dat <= '0;
      r_pend_dp  <= '0;
      r_pend_vld <= 1'b0;
      r_on_len   <= '0;
      r_lz       <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_idx     <= w_idx_nxt;
      r_act_dat <= w_act_dat_nxt;
      r_act_dp  <= w_act_dp_nxt;
      r_on_len  <= w_on_len_nxt;
      r_lz      <= w_lz_nxt;
      // A strobe coinciding with the transfer wins: new data stays pending for the next frame.
      if (dat_stb) begin
        r_pend_dat <= dat;
        r_pend_dp  <= dp;
        r_pend_vld <= 1'b1;
      end else if (w_xfer) begin
        r_pend_vld <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_an    <= '1;
      r_seg   <= 7'h7F;
      r_seg_p <= 1'b1;
      r_fsync <= 1'b0;
    end else begin
      r_an    <= w_an_nxt;
      r_seg   <= hex2seg(w_nib);
      r_seg_p <= ~w_dp_sel;
      r_fsync <= w_frame_start;
    end
  end

  assign AN         = r_an;
  assign seg        = r_seg;
  assign seg_P      = r_seg_p;
  assign frame_sync = r_fsync;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl: stimulus pushes per-slot expectations, a monitor
// summarises each displayed slot from the pins and compares it against the queue.
module tb_seg7_scan_ctrl;

  localparam int N_DIG     = 4;
  localparam int FCLK_KHZ  = 64;
  localparam int FSCAN_KHZ = 1;
  localparam int BLANK_CYC = 4;
  localparam int BRIGHT_W  = 2;
  localparam int P         = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] dat = '0;
  logic [3:0]  dp = '0;
  logic        dat_stb = 1'b0;
  logic        blank_lz = 1'b0;
  logic [1:0]  bright = 2'd3;
  logic [3:0]  AN;
  logic [6:0]  seg;
  logic        seg_P;
  logic        frame_sync;

  seg7_scan_ctrl #(
    .N_DIG(N_DIG), .FCLK_KHZ(FCLK_KHZ), .FSCAN_KHZ(FSCAN_KHZ),
    .BLANK_CYC(BLANK_CYC), .BRIGHT_W(BRIGHT_W)
  ) dut (
    .clk(clk), .rst(rst), .dat(dat), .dp(dp), .dat_stb(dat_stb),
    .blank_lz(blank_lz), .bright(bright), .AN(AN), .seg(seg),
    .seg_P(seg_P), .frame_sync(frame_sync)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         frame;
    int         idx;
    logic [7:0] first;
    logic [7:0] last;
    logic [7:0] len;
    logic [6:0] seg;
    logic       segp;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // segs = {seg idx3, idx2, idx1, idx0}; lN = anode on-length for idx N, 0 = blanked slot.
  task automatic push_frame(input int f, input logic [27:0] segs, input logic [3:0] segp,
                            input int l3, input int l2, input int l1, input int l0);
    int   lens[4];
    exp_t e;
    lens = '{l0, l1, l2, l3};
    for (int k = 0; k < 4; k++) begin
      e.frame = f;
      e.idx   = k;
      e.len   = 8'(lens[k]);
      e.first = (lens[k] > 0) ? 8'd4 : 8'hFF;
      e.last  = (lens[k] > 0) ? 8'(4 + lens[k] - 1) : 8'hFF;
      e.seg   = segs[7*k +: 7];
      e.segp  = segp[k];
      sb.push_back(e);
    end
  endtask

  // ---------------- monitor ----------------
  int         mon_s, mon_idx;
  int         mon_frame = -1;
  bit         synced = 1'b0;
  bit         fresh;
  int         on_cnt, stray;
  logic [7:0] on_first, on_last;
  logic [6:0] seg0;
  logic       segp0;

  always @(negedge clk) begin
    if (rst) begin
      synced = 1'b0;
    end else begin
      fresh = 1'b0;
      if (synced) begin
        if (mon_s == P - 1) begin
          mon_s   = 0;
          mon_idx = (mon_idx == N_DIG - 1) ? 0 : mon_idx + 1;
        end else begin
          mon_s++;
        end
      end else if (frame_sync) begin
        synced  = 1'b1;
        fresh   = 1'b1;
        mon_s   = 0;
        mon_idx = 0;
      end
      if (synced) begin
        if (mon_s == 0) begin
          if (!fresh) check($sformatf("frame_sync i%0d", mon_idx), frame_sync, mon_idx == 0);
          if (mon_idx == 0) mon_frame++;
          on_cnt   = 0;
          stray    = 0;
          on_first = 8'hFF;
          on_last  = 8'hFF;
          seg0     = seg;
          segp0    = seg_P;
        end
        for (int k = 0; k < N_DIG; k++) begin
          if (!AN[k]) begin
            if (k != mon_idx) stray++;
            else begin
              on_cnt++;
              if (on_first == 8'hFF) on_first = 8'(mon_s);
              on_last = 8'(mon_s);
            end
          end
        end
        if (seg != seg0 || seg_P != segp0) stray++;
        if (frame_sync && mon_s != 0) stray++;
        if (mon_s == P - 1) begin
          while (sb.size() > 0 && (sb[0].frame < mon_frame ||
                 (sb[0].frame == mon_frame && sb[0].idx < mon_idx))) begin
            check($sformatf("slot_missed i%0d", sb[0].idx), mon_frame, sb[0].frame);
            void'(sb.pop_front());
          end
          if (sb.size() > 0 && sb[0].frame == mon_frame && sb[0].idx == mon_idx) begin
            check($sformatf("an_window f%0d i%0d", mon_frame, mon_idx),
                  {on_first, on_last, 8'(on_cnt)}, {sb[0].first, sb[0].last, sb[0].len});
            check($sformatf("seg f%0d i%0d", mon_frame, mon_idx), seg0, sb[0].seg);
            check($sformatf("seg_P f%0d i%0d", mon_frame, mon_idx), segp0, sb[0].segp);
            check($sformatf("stray f%0d i%0d", mon_frame, mon_idx), stray, 0);
            void'(sb.pop_front());
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_fs();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_sync && n < 600);
    if (!frame_sync) check("wait_fs_timeout", n, 0);
    #1;
  endtask

  task automatic release_rst();
    int n = 0;
    @(negedge clk);
    rst = 1'b0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_sync && n < 1000);
    check("fsync_after_reset", n, P * N_DIG);
    #1;
  endtask

  task automatic strobe(input logic [15:0] d, input logic [3:0] p);
    dat     = d;
    dp      = p;
    dat_stb = 1'b1;
    @(negedge clk);
    #1 dat_stb = 1'b0;
  endtask

  // Entered at s=0 of a frame; data strobes early, bright/blank_lz change in the last cycle.
  task automatic step(input bit do_stb, input logic [15:0] d, input logic [3:0] p,
                      input logic lz, input logic [1:0] br);
    if (do_stb) strobe(d, p);
    else @(negedge clk);
    repeat (254) @(negedge clk);
    #1;
    blank_lz = lz;
    bright   = br;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_AN", AN, 4'hF);
    check("rst_seg", seg, 7'h7F);
    check("rst_seg_P", seg_P, 1'b1);
    check("rst_frame_sync", frame_sync, 1'b0);
    push_frame(mon_frame + 1, {7'h40, 7'h40, 7'h40, 7'h40}, 4'b1111, 60, 60, 60, 60);
    release_rst();

    step(1'b1, 16'h1234, 4'b0000, 1'b0, 2'd3);
    push_frame(mon_frame + 1, {7'h79, 7'h24, 7'h30, 7'h19}, 4'b1111, 60, 60, 60, 60);
    wait_fs();
    step(1'b0, 16'h0000, 4'b0000, 1'b0, 2'd0);
    push_frame(mon_frame + 1, {7'h79, 7'h24, 7'h30, 7'h19}, 4'b1111, 15, 15, 15, 15);
    wait_fs();
    step(1'b0, 16'h0000, 4'b0000, 1'b0, 2'd2);
    push_frame(mon_frame + 1, {7'h79, 7'h24, 7'h30, 7'h19}, 4'b1111, 45, 45, 45, 45);
    wait_fs();
    step(1'b1, 16'h0005, 4'b0000, 1'b1, 2'd3);
    push_frame(mon_frame + 1, {7'h40, 7'h40, 7'h40, 7'h12}, 4'b1111, 0, 0, 0, 60);
    wait_fs();
    step(1'b1, 16'h0000, 4'b0000, 1'b1, 2'd3);
    push_frame(mon_frame + 1, {7'h40, 7'h40, 7'h40, 7'h40}, 4'b1111, 0, 0, 0, 60);
    wait_fs();
    step(1'b1, 16'h0005, 4'b0100, 1'b1, 2'd3);
    push_frame(mon_frame + 1, {7'h40, 7'h40, 7'h40, 7'h12}, 4'b1011, 0, 60, 60, 60);
    wait_fs();
    step(1'b1, 16'h1234, 4'b0000, 1'b0, 2'd3);
    push_frame(mon_frame + 1, {7'h79, 7'h24, 7'h30, 7'h19}, 4'b1111, 60, 60, 60, 60);
    wait_fs();

    // Strobe mid-frame (idx1 slot): rest of this frame keeps 1234, next frame shows ABCD.
    repeat (74) @(negedge clk);
    #1 strobe(16'hABCD, 4'b0000);
    repeat (180) @(negedge clk);
    #1 push_frame(mon_frame + 1, {7'h08, 7'h03, 7'h46, 7'h21}, 4'b1111, 60, 60, 60, 60);
    wait_fs();

    // Strobe in the transfer cycle while 7777 is pending.
    strobe(16'h7777, 4'b0000);
    repeat (254) @(negedge clk);
    #1 push_frame(mon_frame + 1, {7'h78, 7'h78, 7'h78, 7'h78}, 4'b1111, 60, 60, 60, 60);
    dat     = 16'h5555;
    dat_stb = 1'b1;
    @(negedge clk);
    check("xfer_cycle_fsync", frame_sync, 1'b1);
    #1 dat_stb = 1'b0;
    push_frame(mon_frame + 1, {7'h12, 7'h12, 7'h12, 7'h12}, 4'b1111, 60, 60, 60, 60);
    repeat (255) @(negedge clk);
    wait_fs();
    wait_fs();
    check("sb_drained_pre_reset", sb.size(), 0);

    // Mid-slot asynchronous reset with data pending; reset must discard it.
    strobe(16'h0F0F, 4'b1111);
    repeat (10) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_AN", AN, 4'hF);
    check("async_rst_seg", seg, 7'h7F);
    check("async_rst_seg_P", seg_P, 1'b1);
    check("async_rst_frame_sync", frame_sync, 1'b0);
    repeat (3) @(negedge clk);
    push_frame(mon_frame + 1, {7'h40, 7'h40, 7'h40, 7'h40}, 4'b1111, 60, 60, 60, 60);
    push_frame(mon_frame + 2, {7'h40, 7'h40, 7'h40, 7'h40}, 4'b1111, 60, 60, 60, 60);
    release_rst();
    wait_fs();
    wait_fs();
    check("sb_drained_end", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    n_errors++;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
